// File: rtl/dat_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : dat_tx_serializer
// Purpose  : Pulls 32-bit words from the host FIFO and serializes them onto
//            the 4-bit SD DAT bus as start bit, data, per-line CRC16 and end
//            bit, for single- or multi-block writes.
// Revision : 1.0 - initial release
// ============================================================================
module dat_tx_serializer #(
  parameter int BLK_W   = 12,
  parameter int CNT_W   = 16,
  parameter int GAP_CYC = 2     // must be >= 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             multi_block,
  input  logic [BLK_W-1:0] block_size,
  input  logic [CNT_W-1:0] block_count,
  input  logic [31:0]      buffer_in,
  input  logic             fifo_ack,
  output logic             pop,
  output logic [3:0]       card_out,
  output logic             dat_oe,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  // Word counter must hold 128 (512-byte default) and up to 1023 words.
  localparam int WRD_W = (BLK_W > 10) ? BLK_W - 2 : 8;
  localparam int CNT_CW = ($clog2(GAP_CYC + 1) > 4) ? $clog2(GAP_CYC + 1) : 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_CRC   = 3'd4,
    S_END   = 3'd5,
    S_GAP   = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_word;
  logic [2:0]        r_nib;
  logic [WRD_W-1:0]  r_words_cfg;
  logic [WRD_W-1:0]  r_words_left;
  logic [CNT_W-1:0]  r_blocks_left;
  logic [CNT_CW-1:0] r_cnt;
  logic [3:0][15:0]  r_crc;
  logic              r_err;
  logic              r_underrun;

  logic              w_uflow;
  logic              w_accept;
  logic [3:0]        w_nibble;
  logic [WRD_W-1:0]  w_bs_words;
  logic [WRD_W-1:0]  w_words;
  logic [CNT_W-1:0]  w_blocks;
  logic              w_unused_bits;

  assign w_unused_bits = ^block_size[1:0];
  assign w_accept      = (r_state == S_IDLE) && start && !abort;
  assign w_bs_words    = WRD_W'(block_size[BLK_W-1:2]);
  assign w_words       = (w_bs_words == '0) ? WRD_W'(128) : w_bs_words;
  assign w_blocks      = (multi_block && (block_count != '0)) ? block_count : CNT_W'(1);
  // Byte 0 first, high nibble of each byte first.
  assign w_nibble      = r_word[{r_nib[2:1], ~r_nib[0], 2'b00} +: 4];
  assign underrun      = r_underrun;
  assign busy          = (r_state != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and bus/strobe outputs.
  always_comb begin
    w_next   = r_state;
    pop      = 1'b0;
    card_out = 4'hF;
    dat_oe   = 1'b0;
    done     = 1'b0;
    w_uflow  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (abort) w_next = S_END;
        else if (fifo_ack) begin
          pop    = 1'b1;
          w_next = S_START;
        end
      end
      S_START: begin
        dat_oe   = 1'b1;
        card_out = 4'h0;
        w_next   = abort ? S_END : S_DATA;
      end
      S_DATA: begin
        dat_oe   = 1'b1;
        card_out = w_nibble;
        if (abort) w_next = S_END;
        else if (r_nib == 3'd7) begin
          if (r_words_left == '0) w_next = S_CRC;
          else if (fifo_ack)      pop    = 1'b1;
          else begin
            w_uflow = 1'b1;
            w_next  = S_END;
          end
        end
      end
      S_CRC: begin
        dat_oe   = 1'b1;
        card_out = {r_crc[3][15], r_crc[2][15], r_crc[1][15], r_crc[0][15]};
        if (abort || (r_cnt == CNT_CW'(15))) w_next = S_END;
      end
      S_END: begin
        dat_oe = 1'b1;
        if (!abort && !r_err && (r_blocks_left > CNT_W'(1))) w_next = S_GAP;
        else begin
          done   = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_GAP: begin
        dat_oe = 1'b1;
        if (abort) w_next = S_END;
        else if (r_cnt == CNT_CW'(GAP_CYC - 1)) w_next = S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: settings, word/nibble counters, CRC lanes and error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word        <= '0;
      r_nib         <= '0;
      r_words_cfg   <= '0;
      r_words_left  <= '0;
      r_blocks_left <= '0;
      r_cnt         <= '0;
      r_crc         <= '0;
      r_err         <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_cnt <= (w_next != r_state) ? '0 : r_cnt + CNT_CW'(1);
      if (abort && (r_state != S_IDLE)) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_words_cfg   <= w_words;
            r_blocks_left <= w_blocks;
            r_underrun    <= 1'b0;
            r_err         <= 1'b0;
          end
        end
        S_FETCH: begin
          if (pop) begin
            r_word       <= buffer_in;
            r_nib        <= '0;
            r_words_left <= r_words_cfg - WRD_W'(1);
            r_crc        <= '0;
          end
        end
        S_DATA: begin
          r_nib <= r_nib + 3'd1;
          for (int i = 0; i < 4; i++)
            r_crc[i] <= {r_crc[i][14:0], 1'b0} ^
                        ((r_crc[i][15] ^ card_out[i]) ? 16'h1021 : 16'h0000);
          if (pop) begin
            r_word       <= buffer_in;
            r_words_left <= r_words_left - WRD_W'(1);
          end
          if (w_uflow) begin
            r_underrun <= 1'b1;
            r_err      <= 1'b1;
          end
        end
        S_CRC: begin
          for (int i = 0; i < 4; i++) r_crc[i] <= {r_crc[i][14:0], 1'b0};
        end
        S_END: begin
          if (r_blocks_left != '0) r_blocks_left <= r_blocks_left - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dat_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dat_tx_serializer
// Purpose  : Directed self-checking bench for dat_tx_serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dat_tx_serializer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        multi_block = 1'b0;
  logic [11:0] block_size = 12'd4;
  logic [15:0] block_count = 16'd1;
  logic [31:0] buffer_in = 32'h0;
  logic        fifo_ack = 1'b0;
  logic        pop;
  logic [3:0]  card_out;
  logic        dat_oe;
  logic        busy;
  logic        done;
  logic        underrun;

  int n_cmp = 0;
  int n_err = 0;
  int pop_cnt = 0;
  int bad_pop = 0;
  int done_cnt = 0;
  int oe_cnt = 0;
  logic [3:0] log_q[$];

  dat_tx_serializer #(.BLK_W(12), .CNT_W(16), .GAP_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .multi_block(multi_block), .block_size(block_size), .block_count(block_count),
    .buffer_in(buffer_in), .fifo_ack(fifo_ack), .pop(pop), .card_out(card_out),
    .dat_oe(dat_oe), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Observe outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (pop) pop_cnt++;
    if (pop && !fifo_ack) bad_pop++;
    if (done) done_cnt++;
    if (dat_oe) begin
      oe_cnt++;
      log_q.push_back(card_out);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_timeout_busy"}, busy, 0);
  endtask

  // One 4-byte block of 32'h12345678, checked nibble by nibble.
  task automatic ref_frame(input string tag);
    logic [15:0] c0, c1, c2, c3;
    logic [3:0]  exp_n[26];
    logic [3:0]  dat[8];
    int p0, d0, o0, b;
    c0 = 16'h14A0; c1 = 16'h1290; c2 = 16'hE75F; c3 = 16'h48C4;
    dat = '{4'h7, 4'h8, 4'h5, 4'h6, 4'h3, 4'h4, 4'h1, 4'h2};
    exp_n[0] = 4'h0;
    for (int i = 0; i < 8; i++) exp_n[1+i] = dat[i];
    for (int k = 0; k < 16; k++)
      exp_n[9+k] = {c3[15-k], c2[15-k], c1[15-k], c0[15-k]};
    exp_n[25] = 4'hF;
    block_size = 12'd4; multi_block = 1'b0; buffer_in = 32'h12345678; fifo_ack = 1'b1;
    p0 = pop_cnt; d0 = done_cnt; o0 = oe_cnt; b = log_q.size();
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_fetch_pop"}, pop, 1);
    step();
    fifo_ack = 1'b0;
    wait_idle(tag, 60);
    chk({tag, "_pops"}, pop_cnt - p0, 1);
    chk({tag, "_dones"}, done_cnt - d0, 1);
    chk({tag, "_oe_cycles"}, oe_cnt - o0, 26);
    for (int i = 0; i < 26; i++)
      chk($sformatf("%s_nib%0d", tag, i), log_q[b+i], exp_n[i]);
    chk({tag, "_oe_after"}, dat_oe, 0);
  endtask

  initial begin
    int p0, d0, o0, b, nz;
    logic [11:0] sizes[2];

    // Reset state
    #1;
    chk("rst_card_out", card_out, 4'hF);
    chk("rst_dat_oe", dat_oe, 0);
    chk("rst_pop", pop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    #20 reset_n = 1'b1;
    step();

    // 1) single 4-byte block
    ref_frame("t1");

    // 2) 512-byte block of zeros, both as 12'h200 and as 0
    sizes[0] = 12'h200; sizes[1] = 12'h000;
    for (int s = 0; s < 2; s++) begin
      block_size = sizes[s]; buffer_in = 32'h0; fifo_ack = 1'b1;
      p0 = pop_cnt; d0 = done_cnt; o0 = oe_cnt; b = log_q.size();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_idle("t2", 1200);
      fifo_ack = 1'b0;
      nz = 0;
      for (int i = 0; i < 1041; i++) if (log_q[b+i] !== 4'h0) nz++;
      chk($sformatf("t2_%0d_pops", s), pop_cnt - p0, 128);
      chk($sformatf("t2_%0d_oe_cycles", s), oe_cnt - o0, 1042);
      chk($sformatf("t2_%0d_nonzero_nibs", s), nz, 0);
      chk($sformatf("t2_%0d_end", s), log_q[b+1041], 4'hF);
      chk($sformatf("t2_%0d_dones", s), done_cnt - d0, 1);
    end

    // 3) three 8-byte blocks; a start while busy must be ignored
    block_size = 12'd8; multi_block = 1'b1; block_count = 16'd3;
    buffer_in = 32'hA5A5A5A5; fifo_ack = 1'b1;
    p0 = pop_cnt; d0 = done_cnt; o0 = oe_cnt; b = log_q.size();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    start = 1'b1; block_size = 12'd4; multi_block = 1'b0;
    step();
    start = 1'b0;
    wait_idle("t3", 300);
    fifo_ack = 1'b0;
    chk("t3_pops", pop_cnt - p0, 6);
    chk("t3_dones", done_cnt - d0, 1);
    chk("t3_oe_cycles", oe_cnt - o0, 106);
    chk("t3_end1", log_q[b+33], 4'hF);
    chk("t3_gap1a", log_q[b+34], 4'hF);
    chk("t3_gap1b", log_q[b+35], 4'hF);
    chk("t3_start2", log_q[b+36], 4'h0);
    chk("t3_gap2a", log_q[b+70], 4'hF);
    chk("t3_gap2b", log_q[b+71], 4'hF);
    chk("t3_start3", log_q[b+72], 4'h0);
    chk("t3_end3", log_q[b+105], 4'hF);

    // block_count=0 in multi-block mode sends a single block
    block_size = 12'd4; multi_block = 1'b1; block_count = 16'd0; fifo_ack = 1'b1;
    d0 = done_cnt; o0 = oe_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle("t3z", 60);
    fifo_ack = 1'b0; multi_block = 1'b0;
    chk("t3z_oe_cycles", oe_cnt - o0, 26);
    chk("t3z_dones", done_cnt - d0, 1);

    // 4) FIFO empties before the second of three words
    block_size = 12'd12; buffer_in = 32'hCAFEF00D; fifo_ack = 1'b1;
    p0 = pop_cnt; d0 = done_cnt; o0 = oe_cnt; b = log_q.size();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    fifo_ack = 1'b0;
    wait_idle("t4", 60);
    chk("t4_underrun", underrun, 1);
    chk("t4_pops", pop_cnt - p0, 1);
    chk("t4_dones", done_cnt - d0, 1);
    chk("t4_oe_cycles", oe_cnt - o0, 10);
    chk("t4_last_data", log_q[b+8], 4'hA);
    chk("t4_end_no_crc", log_q[b+9], 4'hF);
    repeat (3) step();
    chk("t4_underrun_sticky", underrun, 1);

    // 5) abort mid-DATA, then a clean frame
    block_size = 12'd8; buffer_in = 32'h0; fifo_ack = 1'b1;
    p0 = pop_cnt; d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_underrun_cleared", underrun, 0);
    repeat (4) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_end_card_out", card_out, 4'hF);
    chk("t5_end_done", done, 1);
    chk("t5_end_oe", dat_oe, 1);
    step();
    fifo_ack = 1'b0;
    chk("t5_after_oe", dat_oe, 0);
    chk("t5_after_busy", busy, 0);
    chk("t5_pops", pop_cnt - p0, 1);
    chk("t5_dones", done_cnt - d0, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_idle_abort_busy", busy, 0);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("t5_start_with_abort_busy", busy, 0);
    ref_frame("t5_restart");

    // 6) asynchronous reset during CRC
    block_size = 12'd4; buffer_in = 32'h12345678; fifo_ack = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    fifo_ack = 1'b0;
    repeat (12) step();
    chk("t6_in_crc_oe", dat_oe, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_card_out", card_out, 4'hF);
    chk("t6_rst_oe", dat_oe, 0);
    chk("t6_rst_busy", busy, 0);
    step();
    reset_n = 1'b1;
    step();
    ref_frame("t6_after_rst");

    chk("pop_without_ack", bad_pop, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
